dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data SRAM between the CPU data port (m0) and a DMA/loader port (m1). It sits between the processor's load/store interface and the SRAM macro, and drives the macro's active-low CEN/WEN strobes. It issues at most one access per cycle, with round-robin priority, an optional bounded burst lock for m1, and one-cycle read-data return routing.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_pick2.sv | 25 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-SRAM arbiter: default widths, port indices
// and the active-low strobe encoding of the SRAM macro.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  localparam int M0 = 0;
  localparam int M1 = 1;
  localparam int NUM_PORTS = 2;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way priority picker: a lone requester always wins; on a conflict
// i_force_m1 or i_prio=1 selects m1, otherwise m0. Output is one-hot or zero.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_prio,
  input  logic                 i_force_m1,
  output logic [NUM_PORTS-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt[M0] = 1'b1;
      2'b10:   o_gnt[M1] = 1'b1;
      2'b11: begin
        if (i_force_m1 || i_prio) o_gnt[M1] = 1'b1;
        else                      o_gnt[M0] = 1'b1;
      end
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data SRAM between the CPU port (m0) and a DMA port
// (m1): round-robin grant, bounded m1 burst lock, 1-cycle read return routing.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_oen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  logic                 r_prio;
  logic                 r_owner_lock;
  logic [CW-1:0]        r_burst_cnt;
  logic [NUM_PORTS-1:0] r_rd_pend;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt;
  logic                 w_force_m1;
  logic                 w_yield;
  logic                 w_prio_eff;
  logic                 w_we;
  logic                 w_prio_nxt;
  logic                 w_lock_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [NUM_PORTS-1:0] w_rd_pend_nxt;

  // Gating with rst_n keeps grants (and therefore strobes) off during reset.
  assign w_req      = {m1_req, m0_req} & {NUM_PORTS{rst_n}};
  assign w_force_m1 = r_owner_lock & (r_burst_cnt < CNT_LAST);
  assign w_yield    = r_owner_lock & (r_burst_cnt == CNT_LAST);
  assign w_prio_eff = r_prio & ~w_yield;

  rr_pick2 u_pick (
    .i_req      (w_req),
    .i_prio     (w_prio_eff),
    .i_force_m1 (w_force_m1),
    .o_gnt      (w_gnt)
  );

  assign m0_gnt  = w_gnt[M0];
  assign m1_gnt  = w_gnt[M1];
  assign mem_oen = STROBE_ON;

  always_comb begin
    mem_cen = STROBE_OFF;
    mem_a   = '0;
    mem_d   = '0;
    w_we    = 1'b0;
    if (w_gnt[M1]) begin
      mem_cen = STROBE_ON;
      mem_a   = m1_addr;
      mem_d   = m1_wdata;
      w_we    = m1_we;
    end else if (w_gnt[M0]) begin
      mem_cen = STROBE_ON;
      mem_a   = m0_addr;
      mem_d   = m0_wdata;
      w_we    = m0_we;
    end
    mem_wen = w_we ? STROBE_ON : STROBE_OFF;
  end

  always_comb begin
    w_prio_nxt = r_prio;
    if (w_gnt[M0])                        w_prio_nxt = 1'b1;
    else if (w_gnt[M1] && !r_owner_lock)  w_prio_nxt = 1'b0;

    w_lock_nxt = w_gnt[M1] & m1_lock;

    // Count only locked grants that actually made m0 wait; saturates at the
    // yield point so the forced m0 grant always follows.
    w_cnt_nxt = r_burst_cnt;
    if (w_gnt[M0] || !w_lock_nxt)                w_cnt_nxt = '0;
    else if (m0_req && r_burst_cnt != CNT_LAST)  w_cnt_nxt = r_burst_cnt + 1'b1;

    w_rd_pend_nxt = {w_gnt[M1] & ~m1_we, w_gnt[M0] & ~m0_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio       <= 1'b0;
      r_owner_lock <= 1'b0;
      r_burst_cnt  <= '0;
      r_rd_pend    <= '0;
    end else begin
      r_prio       <= w_prio_nxt;
      r_owner_lock <= w_lock_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_rd_pend    <= w_rd_pend_nxt;
    end
  end

  assign m0_rvalid = r_rd_pend[M0];
  assign m1_rvalid = r_rd_pend[M1];
  assign m0_rdata  = r_rd_pend[M0] ? mem_q : '0;
  assign m1_rdata  = r_rd_pend[M1] ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle SRAM attached.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_cen, mem_wen, mem_oen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_q;

  int n_assert = 0;
  int n_fail   = 0;
  logic preload;
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [7:0] lk_exp;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      sram[3] <= 32'hAAAA_0003;
      sram[4] <= 32'hBBBB_0004;
      sram[5] <= 32'h1234_5678;
      mem_q   <= '0;
    end else if (!mem_cen) begin
      if (!mem_wen) sram[mem_a] <= mem_d;
      else          mem_q       <= sram[mem_a];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    m1_lock = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_req();
    rst_n = 0; preload = 1;
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_cen", mem_cen, 1);
    check("rst_wen", mem_wen, 1);
    check("rst_oen", mem_oen, 0);
    check("rst_a", mem_a, 0);
    check("rst_d", mem_d, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    next_cyc();
    preload = 0; rst_n = 1;
    clr_req();

    // Both write continuously: strict alternation starting with m0.
    m0_req = 1; m0_we = 1; m0_addr = 1; m0_wdata = 32'hCAFE_0001;
    m1_req = 1; m1_we = 1; m1_addr = 2; m1_wdata = 32'hBEEF_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wr_m0_gnt", m0_gnt, (i % 2 == 0));
      check("wr_m1_gnt", m1_gnt, (i % 2 == 1));
      check("wr_cen", mem_cen, 0);
      check("wr_wen", mem_wen, 0);
      check("wr_a", mem_a, (i % 2 == 0) ? 1 : 2);
      check("wr_d", mem_d, (i % 2 == 0) ? 32'hCAFE_0001 : 32'hBEEF_0002);
      check("wr_rvalid", {m0_rvalid, m1_rvalid}, 0);
      next_cyc();
    end
    clr_req();
    @(negedge clk);
    check("wr_rvalid_after", {m0_rvalid, m1_rvalid}, 0);
    check("wr_mem1", sram[1], 32'hCAFE_0001);
    check("wr_mem2", sram[2], 32'hBEEF_0002);
    next_cyc();

    // Single m0 read of addr 5.
    m0_req = 1; m0_we = 0; m0_addr = 5;
    @(negedge clk);
    check("rd_m0_gnt", m0_gnt, 1);
    check("rd_m1_gnt", m1_gnt, 0);
    check("rd_cen", mem_cen, 0);
    check("rd_wen", mem_wen, 1);
    check("rd_a", mem_a, 5);
    next_cyc();
    clr_req();
    @(negedge clk);
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    check("rd_m1_rvalid", m1_rvalid, 0);
    check("rd_m1_rdata", m1_rdata, 0);
    check("rd_cen_idle", mem_cen, 1);
    next_cyc();
    @(negedge clk);
    check("rd_m0_rvalid_once", m0_rvalid, 0);
    check("rd_m0_rdata_zero", m0_rdata, 0);
    next_cyc();

    // m1 lock with m0 contending: m1 x3, forced yield to m0, repeat.
    m0_req = 1; m0_we = 1; m0_addr = 6; m0_wdata = 32'h0000_0066;
    m1_req = 1; m1_we = 1; m1_addr = 7; m1_wdata = 32'h0000_0077; m1_lock = 1;
    lk_exp = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("lk_m1_gnt", m1_gnt, lk_exp[i]);
      check("lk_m0_gnt", m0_gnt, !lk_exp[i]);
      next_cyc();
    end
    clr_req();

    // Back-to-back reads: m0 addr 3 then m1 addr 4.
    m0_req = 1; m0_we = 0; m0_addr = 3;
    @(negedge clk);
    check("b2b_m0_gnt", m0_gnt, 1);
    check("b2b_a0", mem_a, 3);
    next_cyc();
    clr_req();
    m1_req = 1; m1_we = 0; m1_addr = 4;
    @(negedge clk);
    check("b2b_m1_gnt", m1_gnt, 1);
    check("b2b_a1", mem_a, 4);
    check("b2b_m0_rvalid", m0_rvalid, 1);
    check("b2b_m0_rdata", m0_rdata, 32'hAAAA_0003);
    check("b2b_m1_rvalid_early", m1_rvalid, 0);
    next_cyc();
    clr_req();
    @(negedge clk);
    check("b2b_m1_rvalid", m1_rvalid, 1);
    check("b2b_m1_rdata", m1_rdata, 32'hBBBB_0004);
    check("b2b_m0_rvalid_late", m0_rvalid, 0);
    check("b2b_m0_rdata_zero", m0_rdata, 0);
    next_cyc();

    // Idle bus.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_cen", mem_cen, 1);
      check("idle_wen", mem_wen, 1);
      check("idle_a", mem_a, 0);
      check("idle_gnt", {m0_gnt, m1_gnt}, 0);
      next_cyc();
    end

    // Two locked m1 reads, then reset while the second read is returning.
    m1_req = 1; m1_we = 0; m1_addr = 4; m1_lock = 1;
    @(negedge clk);
    check("rr_m1_gnt_a", m1_gnt, 1);
    next_cyc();
    @(negedge clk);
    check("rr_m1_gnt_b", m1_gnt, 1);
    check("rr_m1_rvalid_a", m1_rvalid, 1);
    next_cyc();
    rst_n = 0;
    clr_req();
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    check("rr_m1_rvalid_drop", m1_rvalid, 0);
    check("rr_m1_rdata_drop", m1_rdata, 0);
    check("rr_cen", mem_cen, 1);
    check("rr_gnt", {m0_gnt, m1_gnt}, 0);
    next_cyc();
    rst_n = 1;
    m0_we = 0; m0_addr = 3; m1_we = 0; m1_addr = 4; m1_lock = 1;
    @(negedge clk);
    check("rr_post_m0_gnt", m0_gnt, 1);
    check("rr_post_m1_gnt", m1_gnt, 0);
    check("rr_post_m1_rvalid", m1_rvalid, 0);
    next_cyc();
    clr_req();
    @(negedge clk);
    check("rr_post_m0_rdata", m0_rdata, 32'hAAAA_0003);
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
